ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
//
// PURPOSE
//  Converts the byte stream of the PS/2 receiver into per-key held state, plus press/release strobes.
//  Handles the set-2 break prefix F0 and the extended prefix E0.
//  Key set is parametrised, replacing the fixed last-byte-to-keys decode in the game top level.
//  Sits between the PS/2 receiver and the game logic; any_down replaces the top-level userIn flag.
//
// PARAMETERS
//  NUM_KEYS        6                  number of tracked keys (1..16)
//  KEYMAP          {9'h15A,9'h029,9'h174,9'h16B,9'h172,9'h175}
//                                     NUM_KEYS x 9 bits, entry i at [9i+8:9i] = {ext,code}
//                                     default: up,down,left,right (E0), space, enter
//  PREFIX_TIMEOUT  1_000_000          cycles a prefix may wait for its next byte (20 ms @ 50 MHz)
//
// PORTS
//  CLOCK_50     in   1         system clock, all logic on rising edge
//  reset        in   1         asynchronous, active-high
//  rx_data      in   8         byte from PS/2 receiver
//  rx_valid     in   1         one-cycle strobe, rx_data valid
//  clear_all    in   1         synchronous: release every held key
//  key_down     out  NUM_KEYS  level, 1 while key i held
//  key_press    out  NUM_KEYS  1-cycle pulse on 0->1 of key_down[i]
//  key_release  out  NUM_KEYS  1-cycle pulse on 1->0 of key_down[i]
//  any_down     out  1         OR of key_down (registered)
//  last_code    out  8         last non-prefix code byte accepted
//
// BEHAVIOUR
//  - Reset: all outputs 0, parser state IDLE, timeout counter 0.
//  - Parser FSM, states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0,F0 seen):
//    - IDLE: E0->EXT, F0->BRK, other byte = make {0,byte}, stay IDLE.
//    - EXT: F0->EXT_BRK, E0 stays EXT, other = make {1,byte} -> IDLE.
//    - BRK: byte = break {0,byte} -> IDLE.  EXT_BRK: byte = break {1,byte} -> IDLE.
//  - Control bytes FA, AA, EE, FE, E1 are ignored in every state.
//    - Parser returns to IDLE; last_code is unchanged.
//  - Make of mapped key i sets key_down[i]; break clears it.
//    - Only for an exact {ext,code} match against KEYMAP entry i.
//  - Unmapped code: last_code updated, key state unchanged.
//  - Latency: rx_valid in cycle N -> key_down, pulses, any_down and last_code valid in cycle N+1.
//  - any_down follows key_down in the same cycle.
//  - Duplicate KEYMAP entries: every matching index updates.
//  - Typematic repeat (make while held): key_down stays 1, no key_press (unless macro below).
//  - Break for a key not held: no change, no key_release.
//  - Timeout: counter runs while not IDLE and resets on every rx_valid.
//    - At PREFIX_TIMEOUT-1 the FSM returns to IDLE; the dropped prefix produces no output.
//  - clear_all: next cycle key_down = 0, key_release pulses for every previously held key, FSM -> IDLE.
//    - Wins over a same-cycle rx_valid, which is dropped.
//  - reset asserted mid-sequence: immediate return to reset values, no pulses.
//
// CONFIGURATION
//  PS2_REPEAT_EN defined: every make of a mapped key pulses key_press.
//    - Includes typematic repeats while held, for menu auto-repeat.
//  PS2_REPEAT_EN undefined: key_press only on the 0->1 transition (default).
//
// TESTING
//  1. 75 -> key_down=0; E0,75 -> key_down[0]=1, key_press=6'b000001 for 1 cycle, any_down=1.
//  2. E0,F0,75 after case 1 -> key_down=0, key_release[0] pulse, any_down=0, last_code=8'h75.
//  3. 29 three times (held) -> one key_press[4] pulse; with PS2_REPEAT_EN -> three pulses.
//  4. E0,75 then E0,6B then 5A -> key_down=6'b100101; clear_all -> 0, key_release=6'b100101 one cycle.
//  5. E0 then idle PREFIX_TIMEOUT cycles, then 75 -> FSM IDLE, key_down=0 (non-extended 75 unmapped).
//  6. F0 then reset pulse then 29 -> key_down[4]=1, make not break; AA,FA in stream -> no change.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Byte-stream input and key-state output bundle for ps2_key_tracker.
// The master side is the PS/2 receiver plus game logic, and the slave side is the tracker.
interface ps2_key_tracker_if #(
  parameter int NUM_KEYS = 6
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                clear_all;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_down;
  logic [7:0]          last_code;

  modport master (
    output rx_data, rx_valid, clear_all,
    input  key_down, key_press, key_release, any_down, last_code
  );

  modport slave (
    input  rx_data, rx_valid, clear_all,
    output key_down, key_press, key_release, any_down, last_code
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Set-2 PS/2 scan-code parser that produces per-key held state and press/release strobes.
// Optional macro PS2_REPEAT_EN: every make of a mapped key pulses key_press, including typematic repeats.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 6,
  parameter logic [NUM_KEYS*9-1:0] KEYMAP         = {9'h15A, 9'h029, 9'h174, 9'h16B, 9'h172, 9'h175},
  parameter int unsigned           PREFIX_TIMEOUT = 1_000_000
) (
  input logic             CLOCK_50,
  input logic             reset,
  ps2_key_tracker_if.slave bus
);

  localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [NUM_KEYS-1:0] key_down;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_down;
  logic [7:0]          last_code;

  logic                make_ev;
  logic                brk_ev;
  logic                ev_ext;
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] down_next;
  logic [NUM_KEYS-1:0] press_next;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFE) || (b == 8'hE1);
  endfunction

  // Classify the incoming byte as a make or break of {ext,code} given the current prefix state
  always_comb begin
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    if (bus.rx_valid && !bus.clear_all && !is_ctrl(bus.rx_data)) begin
      case (state)
        IDLE: begin
          if (bus.rx_data != 8'hE0 && bus.rx_data != 8'hF0) begin
            make_ev = 1'b1;
          end else begin
            make_ev = 1'b0;
          end
        end
        EXT: begin
          ev_ext = 1'b1;
          if (bus.rx_data != 8'hE0 && bus.rx_data != 8'hF0) begin
            make_ev = 1'b1;
          end else begin
            make_ev = 1'b0;
          end
        end
        BRK: begin
          brk_ev = 1'b1;
        end
        EXT_BRK: begin
          ev_ext = 1'b1;
          brk_ev = 1'b1;
        end
        default: begin
          make_ev = 1'b0;
        end
      endcase
    end else begin
      make_ev = 1'b0;
    end
  end

  // Exact {ext,code} match against every keymap entry, so duplicate entries all update
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if ({ev_ext, bus.rx_data} == KEYMAP[9*i +: 9]) begin
        hit[i] = 1'b1;
      end else begin
        hit[i] = 1'b0;
      end
    end
  end

  // Next held-key vector and press strobes; clear_all overrides any same-cycle byte
  always_comb begin
    down_next  = key_down;
    press_next = '0;
    if (bus.clear_all) begin
      down_next = '0;
    end else if (make_ev) begin
      down_next = key_down | hit;
    end else if (brk_ev) begin
      down_next = key_down & ~hit;
    end else begin
      down_next = key_down;
    end
`ifdef PS2_REPEAT_EN
    if (make_ev) begin
      press_next = hit;
    end else begin
      press_next = '0;
    end
`else
    press_next = down_next & ~key_down;
`endif
  end

  // Parser FSM, prefix timeout and all registered outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_down    <= 1'b0;
      last_code   <= 8'h00;
    end else begin
      key_down    <= down_next;
      key_press   <= press_next;
      key_release <= key_down & ~down_next;
      any_down    <= |down_next;
      if (make_ev || brk_ev) begin
        last_code <= bus.rx_data;
      end else begin
        last_code <= last_code;
      end

      if (bus.clear_all) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (bus.rx_valid) begin
        cnt <= '0;
        if (is_ctrl(bus.rx_data)) begin
          state <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (bus.rx_data == 8'hE0) begin
                state <= EXT;
              end else if (bus.rx_data == 8'hF0) begin
                state <= BRK;
              end else begin
                state <= IDLE;
              end
            end
            EXT: begin
              if (bus.rx_data == 8'hF0) begin
                state <= EXT_BRK;
              end else if (bus.rx_data == 8'hE0) begin
                state <= EXT;
              end else begin
                state <= IDLE;
              end
            end
            BRK:     state <= IDLE;
            EXT_BRK: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end else if (state != IDLE) begin
        // A prefix whose follow-up byte never arrives is silently dropped
        if (cnt == CNT_LAST) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.key_down    = key_down;
  assign bus.key_press   = key_press;
  assign bus.key_release = key_release;
  assign bus.any_down    = any_down;
  assign bus.last_code   = last_code;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed-vector bench for ps2_key_tracker using the default keymap and a short prefix timeout.
module tb_ps2_key_tracker;
  localparam int NK = 6;
  localparam int unsigned PT = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  ps2_key_tracker_if #(.NUM_KEYS(NK)) bus ();

  ps2_key_tracker #(.NUM_KEYS(NK), .PREFIX_TIMEOUT(PT)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle rx_valid strobe; returns at the negedge where the result is visible
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    logic [5:0] rep_press;
`ifdef PS2_REPEAT_EN
    rep_press = 6'h10;
`else
    rep_press = 6'h00;
`endif
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.clear_all = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("rst_down", 32'(bus.key_down), 32'h0);
    check_vec("rst_any", 32'(bus.any_down), 32'h0);
    check_vec("rst_last", 32'(bus.last_code), 32'h0);
    rst = 1'b0;

    // 1: plain 75 is unmapped, E0 75 is up
    send_byte(8'h75);
    check_vec("t1_plain75_down", 32'(bus.key_down), 32'h0);
    check_vec("t1_plain75_last", 32'(bus.last_code), 32'h75);
    send_byte(8'hE0);
    check_vec("t1_prefix_last", 32'(bus.last_code), 32'h75);
    send_byte(8'h75);
    check_vec("t1_up_down", 32'(bus.key_down), 32'h01);
    check_vec("t1_up_press", 32'(bus.key_press), 32'h01);
    check_vec("t1_any", 32'(bus.any_down), 32'h1);
    @(negedge clk);
    check_vec("t1_press_1cyc", 32'(bus.key_press), 32'h00);

    // 2: extended break
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_vec("t2_down", 32'(bus.key_down), 32'h00);
    check_vec("t2_release", 32'(bus.key_release), 32'h01);
    check_vec("t2_any", 32'(bus.any_down), 32'h0);
    check_vec("t2_last", 32'(bus.last_code), 32'h75);
    @(negedge clk);
    check_vec("t2_release_1cyc", 32'(bus.key_release), 32'h00);

    // 3: typematic repeat of space
    send_byte(8'h29);
    check_vec("t3_press_first", 32'(bus.key_press), 32'h10);
    send_byte(8'h29);
    check_vec("t3_press_rep2", 32'(bus.key_press), 32'(rep_press));
    send_byte(8'h29);
    check_vec("t3_press_rep3", 32'(bus.key_press), 32'(rep_press));
    check_vec("t3_down", 32'(bus.key_down), 32'h10);
    // control byte between F0 and 29 drops the break prefix
    send_byte(8'hF0);
    send_byte(8'hFA);
    check_vec("t3_ctrl_last", 32'(bus.last_code), 32'h29);
    send_byte(8'h29);
    check_vec("t3_ctrl_make", 32'(bus.key_down), 32'h10);
    send_byte(8'hF0);
    send_byte(8'h29);
    check_vec("t3_brk_release", 32'(bus.key_release), 32'h10);
    send_byte(8'hF0);
    send_byte(8'h29);
    check_vec("t3_brk_not_held", 32'(bus.key_release), 32'h00);
    check_vec("t3_brk_not_held_down", 32'(bus.key_down), 32'h00);

    // 4: three keys, plain 5A is not the extended enter entry, then clear_all with colliding byte
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hE0); send_byte(8'h5A);
    check_vec("t4_down", 32'(bus.key_down), 32'h25);
    send_byte(8'h5A);
    check_vec("t4_plain5a_down", 32'(bus.key_down), 32'h25);
    check_vec("t4_plain5a_last", 32'(bus.last_code), 32'h5A);
    @(negedge clk);
    bus.clear_all = 1'b1;
    bus.rx_data   = 8'h29;
    bus.rx_valid  = 1'b1;
    @(negedge clk);
    bus.clear_all = 1'b0;
    bus.rx_valid  = 1'b0;
    check_vec("t4_clr_down", 32'(bus.key_down), 32'h00);
    check_vec("t4_clr_release", 32'(bus.key_release), 32'h25);
    check_vec("t4_clr_any", 32'(bus.any_down), 32'h0);
    check_vec("t4_clr_last", 32'(bus.last_code), 32'h5A);
    @(negedge clk);
    check_vec("t4_release_1cyc", 32'(bus.key_release), 32'h00);

    // 5: prefix survives a short gap, times out after a long one
    send_byte(8'hE0);
    repeat (5) @(negedge clk);
    send_byte(8'h75);
    check_vec("t5_short_gap", 32'(bus.key_down), 32'h01);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0);
    repeat (PT) @(negedge clk);
    send_byte(8'h75);
    check_vec("t5_timeout_down", 32'(bus.key_down), 32'h00);
    check_vec("t5_timeout_last", 32'(bus.last_code), 32'h75);

    // 6: reset mid-sequence, then space must be a make
    send_byte(8'hE0); send_byte(8'h6B);
    send_byte(8'hF0);
    rst = 1'b1;
    #1;
    check_vec("t6_async_down", 32'(bus.key_down), 32'h00);
    check_vec("t6_async_last", 32'(bus.last_code), 32'h00);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h29);
    check_vec("t6_make_down", 32'(bus.key_down), 32'h10);
    check_vec("t6_make_press", 32'(bus.key_press), 32'h10);
    send_byte(8'hAA);
    send_byte(8'hFA);
    check_vec("t6_ctrl_down", 32'(bus.key_down), 32'h10);
    check_vec("t6_ctrl_last", 32'(bus.last_code), 32'h29);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
